// File: rtl/wiener_bin_ctrl.sv
// Spike-count bin sequencer: unpacks 64-bit words into four 16-bit counts written to
// the active ping-pong bank, then hands each completed bin to the Wiener decoder.
module wiener_bin_ctrl #(
    parameter  int MAX_WORDS = 32,
    localparam int IDX_W     = $clog2(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IDX_W:0]   cfg_words,
    input  logic [63:0]      data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             wr_en,
    output logic [IDX_W+2:0] wr_addr,
    output logic [15:0]      wr_data,
    input  logic             dec_busy,
    output logic             dec_start,
    output logic             dec_bank,
    output logic [15:0]      bin_cnt,
    output logic             overrun,
    output logic [15:0]      overrun_cnt
);

    localparam logic [IDX_W:0] WORDS_MAX = (IDX_W + 1)'(MAX_WORDS);
    localparam logic [IDX_W:0] WORDS_ONE = (IDX_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_UNPACK,
        S_ISSUE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_bank;
    logic             r_dec_bank;
    logic [IDX_W-1:0] r_word_idx;
    logic [1:0]       r_lane;
    logic [IDX_W:0]   r_words_lat;
    logic [63:0]      r_data;
    logic             r_abort;
    logic [15:0]      r_bin_cnt;
    logic [15:0]      r_overrun_cnt;

    logic [IDX_W:0]   w_cfg_clamped;
    logic             w_last_word;
    logic             w_lane_last;
    logic [15:0]      w_lane_data;

    assign w_cfg_clamped = (cfg_words == '0 || cfg_words > WORDS_MAX) ? WORDS_MAX : cfg_words;
    assign w_last_word   = ({1'b0, r_word_idx} == (r_words_lat - WORDS_ONE));
    assign w_lane_last   = (r_lane == 2'd3);

    // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (en) w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (!en)             w_state_nxt = S_IDLE;
                else if (data_valid) w_state_nxt = S_UNPACK;
            end
            S_UNPACK: begin
                if (w_lane_last) begin
                    if (r_abort || !en) w_state_nxt = S_IDLE;
                    else if (w_last_word) w_state_nxt = S_ISSUE;
                    else                  w_state_nxt = S_COLLECT;
                end
            end
            S_ISSUE: begin
                w_state_nxt = en ? S_COLLECT : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_lane_data = r_data[15:0];
        unique case (r_lane)
            2'd0: w_lane_data = r_data[15:0];
            2'd1: w_lane_data = r_data[31:16];
            2'd2: w_lane_data = r_data[47:32];
            2'd3: w_lane_data = r_data[63:48];
            default: w_lane_data = r_data[15:0];
        endcase
    end

    assign data_ready  = (r_state == S_COLLECT);
    assign wr_en       = (r_state == S_UNPACK);
    assign wr_addr     = {r_bank, r_lane, r_word_idx};
    assign wr_data     = w_lane_data;
    assign dec_start   = (r_state == S_ISSUE) && !dec_busy;
    assign overrun     = (r_state == S_ISSUE) && dec_busy;
    // The bank being issued appears in the same cycle as the start pulse, then holds.
    assign dec_bank    = dec_start ? r_bank : r_dec_bank;
    assign bin_cnt     = r_bin_cnt;
    assign overrun_cnt = r_overrun_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_bank        <= 1'b0;
            r_dec_bank    <= 1'b0;
            r_word_idx    <= '0;
            r_lane        <= 2'd0;
            r_words_lat   <= '0;
            r_data        <= '0;
            r_abort       <= 1'b0;
            r_bin_cnt     <= '0;
            r_overrun_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_words_lat <= w_cfg_clamped;
                        r_word_idx  <= '0;
                        r_lane      <= 2'd0;
                        r_abort     <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (!en) begin
                        r_word_idx <= '0;
                    end else if (data_valid) begin
                        r_data <= data_in;
                        r_lane <= 2'd0;
                    end
                end
                S_UNPACK: begin
                    r_lane <= r_lane + 2'd1;
                    if (!en) r_abort <= 1'b1;
                    if (w_lane_last) begin
                        r_abort <= 1'b0;
                        if (r_abort || !en || w_last_word) r_word_idx <= '0;
                        else                               r_word_idx <= r_word_idx + 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_word_idx <= '0;
                    // A busy decoder keeps the bank so the one it is reading is never written.
                    if (!dec_busy) begin
                        r_dec_bank <= r_bank;
                        r_bank     <= ~r_bank;
                        r_bin_cnt  <= r_bin_cnt + 16'd1;
                    end else if (r_overrun_cnt != 16'hFFFF) begin
                        r_overrun_cnt <= r_overrun_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/wiener_bin_ctrl.md
Name: wiener_bin_ctrl

Overview:
Sequencer between the 64-bit spike-count stream and the Wiener decoder's ping-pong count RAM. It unpacks each 64-bit word into four 16-bit channel counts and writes them into the active RAM bank. After a configured number of words (one 1 ms bin) it hands the filled bank to the decoder with a start pulse. If the decoder is still busy at bin completion, the bin is dropped and an overrun is counted.

Parameters:
MAX_WORDS, 32, maximum 64-bit words per bin (4 channels per word, so 128 channels max); sets the word-index width of 5 bits.

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk
en  in  1  run enable
cfg_words  in  6  words per bin; 0 or any value >32 is treated as 32
data_in  in  64  four 16-bit counts; lane k = data_in[16k+15:16k]
data_valid  in  1  word valid; upstream holds data_in/data_valid until accepted
data_ready  out  1  block can accept a word this cycle
wr_en  out  1  RAM write strobe
wr_addr  out  8  {bank, lane[1:0], word_idx[4:0]}
wr_data  out  16  channel count for the current lane
dec_busy  in  1  decoder is processing a bank
dec_start  out  1  one-cycle start pulse to the decoder
dec_bank  out  1  bank to decode; valid when dec_start is high and held until the next dec_start
bin_cnt  out  16  bins issued to the decoder; wraps at 0xFFFF->0
overrun  out  1  one-cycle pulse when a bin is dropped
overrun_cnt  out  16  dropped bins; saturates at 0xFFFF

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; bank=0; word_idx=0; lane=0; all outputs 0, including dec_bank, bin_cnt and overrun_cnt. Reset applied mid-bin or mid-unpack aborts immediately; no further writes occur.
- States: IDLE, COLLECT, UNPACK, ISSUE.
- data_ready = (state==COLLECT). A word is accepted on a cycle where data_valid && data_ready.
- IDLE -> COLLECT when en=1. On this transition: cfg_words is latched into words_lat after clamping, word_idx=0, lane=0. cfg_words changes are ignored outside IDLE.
- COLLECT on accept: capture data_in into a 64-bit register, then go to UNPACK.
- UNPACK lasts exactly 4 cycles, lane 0..3. Each cycle: wr_en=1, wr_data = captured lane, wr_addr = {bank, lane, word_idx}.
- After lane 3:
  - if word_idx == words_lat-1, go to ISSUE;
  - otherwise word_idx+1 and return to COLLECT.
- Latency: word accepted at cycle T; writes occur at T+1..T+4; T+5 is COLLECT (data_ready=1) or ISSUE. Maximum throughput is 1 word per 5 cycles.
- ISSUE (1 cycle), with word_idx reset to 0:
  - if dec_busy=0: dec_start=1, dec_bank=bank, bank toggles, bin_cnt+1;
  - if dec_busy=1: overrun=1, overrun_cnt+1 (saturating), bank unchanged, so the next bin overwrites the same bank and the bank the decoder is reading is never written.
  - Then go to COLLECT if en=1, otherwise IDLE.
- en deasserted:
  - in COLLECT: go to IDLE next cycle and discard the partial bin (word_idx=0, bank unchanged, no dec_start);
  - in UNPACK: finish the current word's 4 writes, then go to IDLE with the partial bin discarded, even if that word was the last one of the bin.
- dec_busy is sampled only in ISSUE. A dec_busy value of 1 that coincides with ISSUE counts as busy.
- data_valid while data_ready=0 has no effect.

Test Plan:
- Reset, en=1, cfg_words=2, send words 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005 with dec_busy=0 -> wr_addr 0x00,0x20,0x40,0x60,0x01,0x21,0x41,0x61 carrying data 1..8; dec_start pulse 5 cycles after the second accept with dec_bank=0; bin_cnt=1; next bin writes use addresses 0x80 and up.
- Continuous data_valid with cfg_words=0 -> 32 words per bin; data_ready low exactly 4 of every 5 cycles within a bin; dec_start every 161 cycles; dec_bank alternates 0,1,0.
- dec_busy=1 at ISSUE -> overrun pulse, overrun_cnt=1, no dec_start, bin_cnt unchanged; next bin rewrites the same bank addresses; with dec_busy=0 it then issues with the same dec_bank.
- en dropped at lane 1 of the last word of a bin -> lanes 2 and 3 are still written, no dec_start, state IDLE; re-enable with cfg_words=1 -> bin completes after a single word using the unchanged bank.
- Force overrun_cnt to 0xFFFF and create another overrun -> overrun pulses, count stays 0xFFFF; bin_cnt wraps from 0xFFFF to 0 on issue.
- rst=0 during UNPACK lane 2 -> wr_en low on the next cycle, all outputs 0; after release and en=1, the first write goes to address 0x00.
